// File: rtl/game_pkg.sv
// Shared types and constants for the basketball round controller: FSM states,
// per-hoop point values, score saturation value and display value widths.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    PLAY   = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int VAL_W = 8;
  localparam int PTS_W = 9;
  localparam int SCORE_MAX = 99;

  localparam logic [PTS_W-1:0] PTS_HOOP0 = 9'd1;
  localparam logic [PTS_W-1:0] PTS_HOOP1 = 9'd2;
  localparam logic [PTS_W-1:0] PTS_HOOP2 = 9'd3;

endpackage

// File: rtl/hoop_debounce.sv
// Two-flop synchronizer, stable-sample debouncer and rising-edge pulse for one
// raw board input; the pulse lasts one cycle when a debounced 0->1 is accepted.
module hoop_debounce #(
  parameter int DEB_CYCLES = 50_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic sync_p0;
  logic sync_p1;
  logic stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      // Count consecutive samples that disagree with the accepted level.
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_p1;
        cnt    <= '0;
        rise   <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_round_controller.sv
// Timed basketball round sequencer: start -> countdown with hoop scoring ->
// single leaderboard write of the final score.
module game_round_controller #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int ROUND_SECS = 30,
  parameter int DEB_CYCLES = 50_000,
  parameter int SCORE_MAX  = game_pkg::SCORE_MAX
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] hoop_in,
  output logic [7:0] time_left,
  output logic [7:0] score,
  output logic       playing,
  output logic       round_over,
  output logic       tick_1s,
  output logic       lb_wr_en,
  output logic [7:0] lb_score
);
  import game_pkg::*;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [VAL_W-1:0] SECS      = VAL_W'(ROUND_SECS);
  localparam logic [VAL_W-1:0] CAP       = VAL_W'(SCORE_MAX);

  state_t state;
  state_t state_nx;
  logic start_evt;
  logic [2:0] hoop_evt;
  logic [TW-1:0] tick_cnt;
  logic tick;

  hoop_debounce #(.DEB_CYCLES(1)) u_start (
    .clock(clock), .reset(reset), .raw(start), .rise(start_evt)
  );

  for (genvar i = 0; i < 3; i++) begin : g_hoop
    hoop_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_hoop (
      .clock(clock), .reset(reset), .raw(hoop_in[i]), .rise(hoop_evt[i])
    );
  end

  // Sum is formed one bit wider than the score so the cap test never sees a wrap.
  function automatic logic [VAL_W-1:0] sat_add(input logic [VAL_W-1:0] base,
                                               input logic [2:0] evt);
    logic [PTS_W-1:0] sum;
    sum = {1'b0, base}
        + (evt[0] ? PTS_HOOP0 : '0)
        + (evt[1] ? PTS_HOOP1 : '0)
        + (evt[2] ? PTS_HOOP2 : '0);
    return (sum > {1'b0, CAP}) ? CAP : sum[VAL_W-1:0];
  endfunction

  assign tick = (state == PLAY) && (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    playing    = 1'b0;
    round_over = 1'b0;
    tick_1s    = 1'b0;
    case (state)
      IDLE:   if (start_evt) state_nx = ARM;
      ARM:    state_nx = PLAY;
      PLAY: begin
        playing = 1'b1;
        tick_1s = tick;
        if (tick && time_left == 8'd1) state_nx = COMMIT;
      end
      COMMIT: state_nx = DONE;
      DONE: begin
        round_over = 1'b1;
        if (start_evt) state_nx = ARM;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      score     <= '0;
      time_left <= SECS;
      tick_cnt  <= '0;
      lb_score  <= '0;
      lb_wr_en  <= 1'b0;
    end else begin
      lb_wr_en <= (state == COMMIT);
      case (state)
        ARM: begin
          score     <= '0;
          time_left <= SECS;
          tick_cnt  <= '0;
        end
        PLAY: begin
          score <= sat_add(score, hoop_evt);
          if (tick) begin
            tick_cnt <= '0;
            if (time_left != 8'd0) time_left <= time_left - 8'd1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        COMMIT: lb_score <= score;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Scenario bench for game_round_controller: a short-round instance for timing
// and FSM scenarios and a long-round instance for scoring and saturation.
module tb_game_round_controller;

  localparam int TICK_DIV   = 10;
  localparam int ROUND_SECS = 3;
  localparam int DEB_CYCLES = 4;
  localparam int LONG_DIV   = 1000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start_l = 1'b0;
  logic [2:0] hoop_in = 3'b000;
  logic [2:0] hoop_l = 3'b000;
  logic [7:0] time_left, score, lb_score, time_left_l, score_l, lb_score_l;
  logic playing, round_over, tick_1s, lb_wr_en;
  logic playing_l, round_over_l, tick_1s_l, lb_wr_en_l;

  int n_checks = 0;
  int n_fail = 0;
  int wr_count = 0;
  int tick_count = 0;
  int tick_count_l = 0;
  int exp_score = 0;

  game_round_controller #(
    .TICK_DIV(TICK_DIV), .ROUND_SECS(ROUND_SECS), .DEB_CYCLES(DEB_CYCLES), .SCORE_MAX(99)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .hoop_in(hoop_in),
    .time_left(time_left), .score(score), .playing(playing), .round_over(round_over),
    .tick_1s(tick_1s), .lb_wr_en(lb_wr_en), .lb_score(lb_score)
  );

  game_round_controller #(
    .TICK_DIV(LONG_DIV), .ROUND_SECS(ROUND_SECS), .DEB_CYCLES(DEB_CYCLES), .SCORE_MAX(99)
  ) dut_long (
    .clock(clock), .reset(reset), .start(start_l), .hoop_in(hoop_l),
    .time_left(time_left_l), .score(score_l), .playing(playing_l), .round_over(round_over_l),
    .tick_1s(tick_1s_l), .lb_wr_en(lb_wr_en_l), .lb_score(lb_score_l)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (lb_wr_en) wr_count++;
    if (tick_1s) tick_count++;
    if (tick_1s_l) tick_count_l++;
  end

  function automatic int pts(input logic [2:0] m);
    return int'(m[0]) + 2 * int'(m[1]) + 3 * int'(m[2]);
  endfunction

  function automatic int sat99(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic start_round(input bit lng);
    int c;
    c = 0;
    if (lng) start_l = 1'b1; else start = 1'b1;
    while (!(lng ? playing_l : playing) && c < 20) begin
      @(negedge clock);
      c++;
    end
    start = 1'b0;
    start_l = 1'b0;
    n_checks++;
    if (c >= 20) begin n_fail++; $display("FAIL start_timeout: waited %0d cycles, required < 20", c); end
  endtask

  // Hold mask on the long instance's sensors, release, and count score changes seen.
  task automatic hoop_pulse_l(input logic [2:0] mask, input int hold, output int changes);
    logic [7:0] prev;
    prev = score_l;
    changes = 0;
    hoop_l = mask;
    for (int i = 0; i < hold + 12; i++) begin
      @(negedge clock);
      if (i == hold - 1) hoop_l = 3'b000;
      if (score_l !== prev) changes++;
      prev = score_l;
    end
  endtask

  task automatic test_reset();
    int w0, t0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    w0 = wr_count;
    t0 = tick_count;
    repeat (100) @(negedge clock);
    n_checks++; if (playing !== 1'b0 || round_over !== 1'b0) begin n_fail++; $display("FAIL reset_idle: playing=%0b round_over=%0b required 0 0", playing, round_over); end
    n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d required 0", score); end
    n_checks++; if (time_left !== 8'd3) begin n_fail++; $display("FAIL reset_time: got %0d required 3", time_left); end
    n_checks++; if (wr_count != w0 || tick_count != t0) begin n_fail++; $display("FAIL reset_strobes: writes=%0d ticks=%0d required 0 0", wr_count - w0, tick_count - t0); end
    n_checks++; if (lb_score !== 8'd0) begin n_fail++; $display("FAIL reset_lb_score: got %0d required 0", lb_score); end
  endtask

  task automatic test_long_scoring();
    int ch, hold, diff, t0;
    logic [2:0] mask;
    t0 = tick_count_l;
    start_round(1);
    exp_score = 0;
    n_checks++; if (time_left_l !== 8'd3 || score_l !== 8'd0) begin n_fail++; $display("FAIL long_arm: time=%0d score=%0d required 3 0", time_left_l, score_l); end
    hoop_pulse_l(3'b010, 6, ch);
    exp_score = 2;
    n_checks++; if (score_l !== 8'(exp_score)) begin n_fail++; $display("FAIL hoop1_score: got %0d required %0d", score_l, exp_score); end
    hoop_pulse_l(3'b001, 3, ch);
    n_checks++; if (score_l !== 8'(exp_score) || ch != 0) begin n_fail++; $display("FAIL glitch_ignored: score=%0d changes=%0d required %0d 0", score_l, ch, exp_score); end
    hoop_pulse_l(3'b111, 6, ch);
    exp_score += 6;
    n_checks++; if (score_l !== 8'(exp_score) || ch != 1) begin n_fail++; $display("FAIL all_three: score=%0d changes=%0d required %0d 1", score_l, ch, exp_score); end
    for (int k = 0; k < 10; k++) begin
      mask = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) begin
        hold = $urandom_range(1, DEB_CYCLES - 1);
      end else begin
        hold = $urandom_range(DEB_CYCLES, DEB_CYCLES + 4);
        exp_score = sat99(exp_score + pts(mask));
      end
      hoop_pulse_l(mask, hold, ch);
      n_checks++; if (score_l !== 8'(exp_score)) begin n_fail++; $display("FAIL random_%0d: mask=%b hold=%0d score=%0d required %0d", k, mask, hold, score_l, exp_score); end
    end
    while (exp_score < 90) begin
      hoop_pulse_l(3'b111, 6, ch);
      exp_score += 6;
    end
    diff = 96 - exp_score;
    case (diff)
      1: mask = 3'b001;
      2: mask = 3'b010;
      3: mask = 3'b100;
      4: mask = 3'b101;
      5: mask = 3'b110;
      default: mask = 3'b111;
    endcase
    hoop_pulse_l(mask, 6, ch);
    exp_score = 96;
    n_checks++; if (score_l !== 8'd96) begin n_fail++; $display("FAIL reach_96: got %0d required 96", score_l); end
    hoop_pulse_l(3'b111, 6, ch);
    exp_score = 99;
    n_checks++; if (score_l !== 8'd99) begin n_fail++; $display("FAIL saturate: got %0d required 99", score_l); end
    hoop_pulse_l(3'b111, 6, ch);
    n_checks++; if (score_l !== 8'd99 || ch != 0) begin n_fail++; $display("FAIL stay_saturated: score=%0d changes=%0d required 99 0", score_l, ch); end
    n_checks++; if (playing_l !== 1'b1) begin n_fail++; $display("FAIL long_still_playing: got %0b required 1", playing_l); end
    ch = 0;
    while (!lb_wr_en_l && ch < 4 * LONG_DIV) begin @(negedge clock); ch++; end
    n_checks++; if (lb_wr_en_l !== 1'b1 || lb_score_l !== 8'd99 || round_over_l !== 1'b1) begin n_fail++; $display("FAIL long_commit: wr=%0b lb_score=%0d over=%0b required 1 99 1", lb_wr_en_l, lb_score_l, round_over_l); end
    n_checks++; if (tick_count_l - t0 != ROUND_SECS) begin n_fail++; $display("FAIL long_ticks: got %0d required %0d", tick_count_l - t0, ROUND_SECS); end
  endtask

  task automatic test_countdown();
    int w0, t0, c;
    w0 = wr_count;
    t0 = tick_count;
    start_round(0);
    n_checks++; if (time_left !== 8'd3 || score !== 8'd0) begin n_fail++; $display("FAIL arm_init: time=%0d score=%0d required 3 0", time_left, score); end
    for (int exp_t = 2; exp_t >= 0; exp_t--) begin
      c = 0;
      while (!tick_1s && c < 50) begin @(negedge clock); c++; end
      n_checks++; if (c != TICK_DIV - 1) begin n_fail++; $display("FAIL tick_spacing_%0d: waited %0d cycles required %0d", exp_t, c, TICK_DIV - 1); end
      @(negedge clock);
      n_checks++; if (time_left !== 8'(exp_t)) begin n_fail++; $display("FAIL time_left_%0d: got %0d required %0d", exp_t, time_left, exp_t); end
    end
    n_checks++; if (lb_wr_en !== 1'b0 || round_over !== 1'b0) begin n_fail++; $display("FAIL commit_cycle: wr=%0b over=%0b required 0 0", lb_wr_en, round_over); end
    @(negedge clock);
    n_checks++; if (lb_wr_en !== 1'b1 || lb_score !== 8'd0 || round_over !== 1'b1) begin n_fail++; $display("FAIL write_cycle: wr=%0b lb_score=%0d over=%0b required 1 0 1", lb_wr_en, lb_score, round_over); end
    repeat (20) @(negedge clock);
    n_checks++; if (wr_count - w0 != 1 || tick_count - t0 != ROUND_SECS) begin n_fail++; $display("FAIL round_counts: writes=%0d ticks=%0d required 1 %0d", wr_count - w0, tick_count - t0, ROUND_SECS); end
    n_checks++; if (time_left !== 8'd0 || playing !== 1'b0) begin n_fail++; $display("FAIL done_hold: time=%0d playing=%0b required 0 0", time_left, playing); end
  endtask

  task automatic test_play_events();
    int c, w0;
    start_round(0);
    repeat (4) @(negedge clock);
    start = 1'b1;
    repeat (4) @(negedge clock);
    start = 1'b0;
    c = 8;
    while (!(tick_1s && time_left == 8'd2) && c < 60) begin @(negedge clock); c++; end
    n_checks++; if (c != 2 * TICK_DIV - 1) begin n_fail++; $display("FAIL start_in_play: second tick after %0d cycles required %0d", c, 2 * TICK_DIV - 1); end
    // Raw edge timed so its point event coincides with the final tick.
    repeat (4) @(posedge clock);
    @(negedge clock);
    hoop_in = 3'b100;
    w0 = wr_count;
    c = 0;
    while (!tick_1s && c < 20) begin @(negedge clock); c++; end
    n_checks++; if (time_left !== 8'd1 || c != 6) begin n_fail++; $display("FAIL final_tick: time=%0d wait=%0d required 1 6", time_left, c); end
    @(negedge clock);
    n_checks++; if (score !== 8'd3 || lb_wr_en !== 1'b0) begin n_fail++; $display("FAIL final_edge_scored: score=%0d wr=%0b required 3 0", score, lb_wr_en); end
    @(negedge clock);
    n_checks++; if (lb_wr_en !== 1'b1 || lb_score !== 8'd3) begin n_fail++; $display("FAIL final_edge_lb: wr=%0b lb_score=%0d required 1 3", lb_wr_en, lb_score); end
    hoop_in = 3'b000;
    repeat (12) @(negedge clock);
    hoop_in = 3'b011;
    repeat (6) @(negedge clock);
    hoop_in = 3'b000;
    repeat (12) @(negedge clock);
    n_checks++; if (score !== 8'd3 || lb_score !== 8'd3 || round_over !== 1'b1) begin n_fail++; $display("FAIL done_edge_ignored: score=%0d lb_score=%0d over=%0b required 3 3 1", score, lb_score, round_over); end
    n_checks++; if (wr_count - w0 != 1) begin n_fail++; $display("FAIL single_write: got %0d required 1", wr_count - w0); end
  endtask

  task automatic test_restart_and_abort();
    int c, w0, t0;
    start_round(0);
    n_checks++; if (score !== 8'd0 || time_left !== 8'd3 || playing !== 1'b1) begin n_fail++; $display("FAIL restart: score=%0d time=%0d playing=%0b required 0 3 1", score, time_left, playing); end
    hoop_in = 3'b001;
    repeat (6) @(negedge clock);
    hoop_in = 3'b000;
    c = 6;
    while (time_left != 8'd2 && c < 40) begin @(negedge clock); c++; end
    n_checks++; if (score !== 8'd1 || time_left !== 8'd2) begin n_fail++; $display("FAIL pre_abort: score=%0d time=%0d required 1 2", score, time_left); end
    w0 = wr_count;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (playing !== 1'b0 || score !== 8'd0 || time_left !== 8'd3 || round_over !== 1'b0) begin n_fail++; $display("FAIL async_abort: playing=%0b score=%0d time=%0d over=%0b required 0 0 3 0", playing, score, time_left, round_over); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    t0 = tick_count;
    repeat (40) @(negedge clock);
    n_checks++; if (wr_count != w0 || tick_count != t0 || playing !== 1'b0) begin n_fail++; $display("FAIL post_abort: writes=%0d ticks=%0d playing=%0b required 0 0 0", wr_count - w0, tick_count - t0, playing); end
  endtask

  initial begin
    test_reset();
    test_long_scoring();
    test_countdown();
    test_play_events();
    test_restart_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
